// File: rtl/ins_fetch_queue_pkg.sv
// Shared fetch/queue/decode definitions: reset PC, NOP encoding and the
// {pc, instr} entry layout held in the instruction buffer.
package ins_fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [PC_W-1:0]    PC_START = 32'h0040_0020;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  // Occupancy change for one cycle, indexed by {fire_enq, fire_deq}.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'b00,
    OCC_DEQ  = 2'b01,
    OCC_ENQ  = 2'b10,
    OCC_BOTH = 2'b11
  } occ_op_e;

endpackage : ins_fetch_queue_pkg

// File: rtl/ins_fetch_queue_if.sv
// Fetch -> queue -> decode handshake bundle. The slave modport is the queue;
// the master modport is the fetch/decode/redirect side that drives it.
interface ins_fetch_queue_if
  import ins_fetch_queue_pkg::*;
#(
  parameter int PTR_W = 2
) ();

  logic               flush;

  logic               enq_valid;
  logic               enq_ready;
  logic [PC_W-1:0]    enq_pc;
  logic [INSTR_W-1:0] enq_instr;

  logic               deq_valid;
  logic               deq_ready;
  logic [PC_W-1:0]    deq_pc;
  logic [INSTR_W-1:0] deq_instr;
  logic [PC_W-1:0]    deq_pc_plus4;

  logic [PTR_W:0]     count;

  modport slave (
    input  flush,
    input  enq_valid, enq_pc, enq_instr,
    output enq_ready,
    output deq_valid, deq_pc, deq_instr, deq_pc_plus4,
    input  deq_ready,
    output count
  );

  modport master (
    output flush,
    output enq_valid, enq_pc, enq_instr,
    input  enq_ready,
    input  deq_valid, deq_pc, deq_instr, deq_pc_plus4,
    output deq_ready,
    input  count
  );

endinterface : ins_fetch_queue_if

// File: rtl/ins_fetch_queue_adder_32.sv
// Plain 32-bit unsigned adder; the carry-out is dropped so results wrap mod 2**32.
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule : adder_32

// File: rtl/ins_fetch_queue_fifo_ptr.sv
// Wrapping PTR_W-bit FIFO pointer with increment enable and synchronous clear.
// Wrap from DEPTH-1 to 0 falls out of the natural overflow since DEPTH = 2**PTR_W.
module fifo_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule : fifo_ptr

// File: rtl/ins_fetch_queue.sv
// Instruction buffer between fetch and decode: small circular FIFO of
// {pc, instr} pairs with valid/ready on both sides and a redirect flush.
module ins_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset_n,
  ins_fetch_queue_if.slave  q
);

  import ins_fetch_queue_pkg::*;

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;

  logic full;
  logic empty;
  logic fire_enq;
  logic fire_deq;

  // Full/empty come from the occupancy counter only; equal pointers are ambiguous.
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // Flush wins over both sides; a full queue never accepts, even if decode drains.
  assign fire_enq = q.enq_valid & ~full  & ~q.flush;
  assign fire_deq = q.deq_ready & ~empty & ~q.flush;

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (q.flush),
    .inc     (fire_enq),
    .ptr     (wr_ptr)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (q.flush),
    .inc     (fire_deq),
    .ptr     (rd_ptr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (q.flush) begin
      count_q <= '0;
    end else begin
      case (occ_op_e'({fire_enq, fire_deq}))
        OCC_ENQ: count_q <= count_q + (PTR_W+1)'(1);
        OCC_DEQ: count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is reset here only so the head PC reads a defined 0 (and
  // pc+4 reads 4) straight out of reset; nothing else relies on array contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (fire_enq) begin
      mem[wr_ptr] <= '{pc: q.enq_pc, instr: q.enq_instr};
    end
  end

  // Head is read straight from the array: no enq->deq bypass, one cycle latency.
  assign head = mem[rd_ptr];

  assign q.enq_ready = ~full;
  assign q.deq_valid = ~empty;
  assign q.deq_pc    = head.pc;
  assign q.deq_instr = empty ? NOP_WORD : head.instr;
  assign q.count     = count_q;

  adder_32 u_pc_plus4 (
    .a   (head.pc),
    .b   (32'h0000_0004),
    .sum (q.deq_pc_plus4)
  );

endmodule : ins_fetch_queue

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue: reset, fill/drain, wrap traffic,
// flush, mid-traffic reset and PC+4 overflow.
module tb_ins_fetch_queue;

  import ins_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];

  ins_fetch_queue_if #(.PTR_W(PTR_W)) bus ();

  ins_fetch_queue #(
    .DEPTH    (DEPTH),
    .PTR_W    (PTR_W),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_2468;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic dr);
    bus.enq_valid = ev;
    bus.enq_pc    = pc;
    bus.enq_instr = instr_of(pc);
    bus.deq_ready = dr;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, bus.deq_valid}, 32'd1);
    check({tag, "_pc"},    bus.deq_pc,    pc);
    check({tag, "_instr"}, bus.deq_instr, instr_of(pc));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"},     {29'b0, bus.count},     32'd0);
    check({tag, "_deq_valid"}, {31'b0, bus.deq_valid}, 32'd0);
    check({tag, "_enq_ready"}, {31'b0, bus.enq_ready}, 32'd1);
    check({tag, "_nop"},       bus.deq_instr,          32'h0000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();

    // Reset asserted mid-cycle: outputs settle before the next rising edge.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_empty("rst");
    check("rst_pc",     bus.deq_pc,       32'h0000_0000);
    check("rst_plus4",  bus.deq_pc_plus4, 32'h0000_0004);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill to DEPTH with decode stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, PC_START + 32'(4 * i), 1'b0);
      tick();
      check("fill_count", {29'b0, bus.count}, 32'(i + 1));
    end
    check("full_enq_ready", {31'b0, bus.enq_ready}, 32'd0);
    drive(1'b1, 32'h0040_0030, 1'b0);
    tick();
    check("full_drop_count", {29'b0, bus.count}, 32'd4);
    check_head("full_head", PC_START);

    // Full with deq_ready high: only the dequeue happens.
    drive(1'b1, 32'h0040_0030, 1'b1);
    check("first_plus4", bus.deq_pc_plus4, 32'h0040_0024);
    tick();
    check("full_deq_only", {29'b0, bus.count}, 32'd3);
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      check_head("drain", PC_START + 32'(4 * i));
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    check_empty("drained");
    check("drained_stale_pc", bus.deq_pc, PC_START);

    // Concurrent enq+deq at count 2 across several pointer wraps.
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h0050_0000 + 32'(4 * k), 1'b0);
      exp_q.push_back(32'h0050_0000 + 32'(4 * k));
      tick();
    end
    check("conc_prefill", {29'b0, bus.count}, 32'd2);
    for (int k = 2; k < 12; k++) begin
      drive(1'b1, 32'h0050_0000 + 32'(4 * k), 1'b1);
      check_head("conc", exp_q.pop_front());
      exp_q.push_back(32'h0050_0000 + 32'(4 * k));
      tick();
      check("conc_count", {29'b0, bus.count}, 32'd2);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      check_head("conc_tail", exp_q.pop_front());
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    check("conc_done", {29'b0, bus.count}, 32'd0);

    // Move both pointers off slot 0, then hold 3 entries (slots 2,3,0).
    drive(1'b1, 32'h0061_0000, 1'b0);
    tick();
    drive(1'b1, 32'h0061_0004, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0060_0000 + 32'(4 * k), 1'b0);
      tick();
    end
    check("pre_flush_count", {29'b0, bus.count}, 32'd3);

    // Flush with enqueue and dequeue both requested: both suppressed.
    bus.flush = 1'b1;
    drive(1'b1, 32'h0040_0040, 1'b1);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    check_empty("flush");
    check("flush_stale_slot0", bus.deq_pc,       32'h0060_0008);
    check("flush_stale_plus4", bus.deq_pc_plus4, 32'h0060_000C);
    drive(1'b1, 32'h0070_0000, 1'b0);
    tick();
    check("post_flush_count", {29'b0, bus.count}, 32'd1);
    check_head("post_flush_slot0", 32'h0070_0000);
    drive(1'b1, 32'h0070_0004, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    check_head("post_flush_a", 32'h0070_0000);
    tick();
    check_head("post_flush_b", 32'h0070_0004);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("post_flush_empty", {29'b0, bus.count}, 32'd0);

    // Reset pulse of half a cycle with 3 entries held.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0080_0000 + 32'(4 * k), 1'b0);
      tick();
    end
    check("pre_reset_count", {29'b0, bus.count}, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check_empty("midrst");
    check("midrst_pc",    bus.deq_pc,       32'h0000_0000);
    check("midrst_plus4", bus.deq_pc_plus4, 32'h0000_0004);
    #4;
    reset_n = 1'b1;
    drive(1'b1, 32'h0040_0100, 1'b0);
    tick();
    check("post_rst_count", {29'b0, bus.count}, 32'd1);
    check_head("post_rst_head", 32'h0040_0100);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("post_rst_drain", {29'b0, bus.count}, 32'd0);

    // PC+4 wraps to zero at the top of the address space.
    drive(1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check_head("ovf", 32'hFFFF_FFFC);
    check("ovf_plus4", bus.deq_pc_plus4, 32'h0000_0000);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("ovf_drain", {29'b0, bus.count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ins_fetch_queue
